// File: rtl/fwd_hazard_scoreboard_if.sv
//------------------------------------------------------------------------------
// fwd_hazard_scoreboard_if
//
// Purpose : Groups the ID-stage decode fields, the pipeline control inputs and
//           the forwarding/stall outputs of fwd_hazard_scoreboard into a
//           single bundle.
//
// Signals :
//   freeze        global pipeline hold
//   flush         branch taken, instruction in ID is discarded
//   id_valid      ID holds a real instruction
//   id_src1/2     ID source register indices
//   id_uses_src2  src2 is really read by the ID instruction
//   id_wb_en      ID instruction writes a register
//   id_mem_read   ID instruction is a load
//   id_dest       ID destination register index
//   fwd_sel1/2    EXE operand mux selects (0 ID/EX, 1 MEM result, 2 WB data)
//   hazard_stall  hold PC and IF/ID, bubble into EXE
//   stall_count   saturating count of stall cycles
//
// Modports:
//   master  pipeline front end (drives the decode fields, consumes selects)
//   slave   the scoreboard itself
//------------------------------------------------------------------------------
interface fwd_hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  freeze;
    logic                  flush;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_uses_src2;
    logic                  id_wb_en;
    logic                  id_mem_read;
    logic [REG_ADDR_W-1:0] id_dest;
    logic [1:0]            fwd_sel1;
    logic [1:0]            fwd_sel2;
    logic                  hazard_stall;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output freeze, flush, id_valid, id_src1, id_src2, id_uses_src2,
               id_wb_en, id_mem_read, id_dest,
        input  fwd_sel1, fwd_sel2, hazard_stall, stall_count
    );

    modport slave (
        input  freeze, flush, id_valid, id_src1, id_src2, id_uses_src2,
               id_wb_en, id_mem_read, id_dest,
        output fwd_sel1, fwd_sel2, hazard_stall, stall_count
    );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
//------------------------------------------------------------------------------
// fwd_hazard_scoreboard
//
// Purpose : Tracks the register writers in flight in the EXE, MEM and WB
//           stages of the 5-stage pipeline. Produces the EXE operand mux
//           selects and the load-use stall that holds PC and IF/ID.
//
// Ports   :
//   clk   rising-edge clock
//   rst   asynchronous active-low reset, clears every slot and the counter
//   bus   fwd_hazard_scoreboard_if.slave (decode fields in, selects/stall out)
//
// Parameters:
//   REG_ADDR_W  register index width
//   CNT_W       width of the saturating stall counter
//
// Build option:
//   FORWARDING_EN  defined   -> MEM/WB forwarding, only load-use stalls
//                  undefined -> selects tied to 0, stall on any EXE or MEM
//                               writer of a source register
//------------------------------------------------------------------------------
module fwd_hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    fwd_hazard_scoreboard_if.slave        bus
);

    // Writer information kept in every slot.
    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic                  mem_read;
        logic [REG_ADDR_W-1:0] dest;
    } writer_t;

    genvar gi;

    //--------------------------------------------------------------------------
    // Slot state
    //--------------------------------------------------------------------------
    writer_t               exe_wr_reg;
    writer_t               exe_wr_next;
    logic [REG_ADDR_W-1:0] exe_src1_reg;
    logic [REG_ADDR_W-1:0] exe_src1_next;
    logic [REG_ADDR_W-1:0] exe_src2_reg;
    logic [REG_ADDR_W-1:0] exe_src2_next;
    logic                  exe_uses_src2_reg;
    logic                  exe_uses_src2_next;
    writer_t               mem_reg;
    writer_t               wb_reg;
    logic [CNT_W-1:0]      stall_count_reg;
    logic [CNT_W-1:0]      stall_count_next;

    logic                  hazard_stall;

    // A slot produces register r. r0 is hard-wired zero, so it never matches.
    function automatic logic writes(input writer_t s,
                                    input logic [REG_ADDR_W-1:0] r);
        return s.valid && s.wb_en && (s.dest == r) && (r != '0);
    endfunction

    //--------------------------------------------------------------------------
    // Stall detection: combinational from the ID fields and the slot state.
    // Index 0 is source 1 (always read), index 1 is source 2 (read only when
    // id_uses_src2 is set).
    //--------------------------------------------------------------------------
    logic [1:0][REG_ADDR_W-1:0] id_src;
    logic [1:0]                 id_reads;
    logic [1:0]                 stall_hit;

    assign id_src   = {bus.id_src2, bus.id_src1};
    assign id_reads = {bus.id_uses_src2, 1'b1};

    generate
        for (gi = 0; gi < 2; gi++) begin : g_stall
`ifdef FORWARDING_EN
            // Only a load in EXE is too late to forward; anything else is
            // picked up from MEM or WB on the next cycle.
            assign stall_hit[gi] = id_reads[gi] && exe_wr_reg.mem_read &&
                                   writes(exe_wr_reg, id_src[gi]);
`else
            // Without forwarding the consumer waits until its producer has
            // reached WB; the write-first register file covers that stage.
            assign stall_hit[gi] = id_reads[gi] &&
                                   (writes(exe_wr_reg, id_src[gi]) ||
                                    writes(mem_reg,    id_src[gi]));
`endif
        end
    endgenerate

    assign hazard_stall = bus.id_valid && !bus.flush && (|stall_hit);

    //--------------------------------------------------------------------------
    // Forwarding selects: pure function of slot state, so there is no
    // combinational path from the ID inputs to the mux selects.
    //--------------------------------------------------------------------------
    logic [1:0][1:0] fwd_sel;

`ifdef FORWARDING_EN
    logic [1:0][REG_ADDR_W-1:0] exe_src;
    logic [1:0]                 exe_reads;
    logic                       unused_sink;

    assign exe_src   = {exe_src2_reg, exe_src1_reg};
    assign exe_reads = {exe_uses_src2_reg, 1'b1};

    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            // MEM holds the younger value, so it wins over WB.
            assign fwd_sel[gi] = !exe_reads[gi]                 ? 2'd0 :
                                 writes(mem_reg, exe_src[gi])   ? 2'd1 :
                                 writes(wb_reg,  exe_src[gi])   ? 2'd2 :
                                                                  2'd0;
        end
    endgenerate

    // The load flag has no consumer once the writer has reached WB.
    assign unused_sink = wb_reg.mem_read;
`else
    logic unused_sink;

    assign fwd_sel = '0;

    // Operand fields and the WB slot are tracked but only matter when
    // forwarding is built in.
    assign unused_sink = ^{exe_src1_reg, exe_src2_reg, exe_uses_src2_reg,
                           wb_reg};
`endif

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    // A stalled or flushed instruction is replaced by an all-zero bubble so
    // that it can never match as a writer further down the pipe.
    always_comb begin
        exe_wr_next        = '0;
        exe_src1_next      = '0;
        exe_src2_next      = '0;
        exe_uses_src2_next = 1'b0;
        if (bus.id_valid && !bus.flush && !hazard_stall) begin
            exe_wr_next.valid    = 1'b1;
            exe_wr_next.wb_en    = bus.id_wb_en;
            exe_wr_next.mem_read = bus.id_mem_read;
            exe_wr_next.dest     = bus.id_dest;
            exe_src1_next        = bus.id_src1;
            exe_src2_next        = bus.id_src2;
            exe_uses_src2_next   = bus.id_uses_src2;
        end
    end

    // Saturating counter: stops at all-ones instead of wrapping.
    always_comb begin
        stall_count_next = stall_count_reg;
        if (hazard_stall && (stall_count_reg != '1)) begin
            stall_count_next = stall_count_reg + CNT_W'(1);
        end
    end

    //--------------------------------------------------------------------------
    // State registers. freeze outranks flush and stall: nothing moves.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_wr_reg        <= '0;
            exe_src1_reg      <= '0;
            exe_src2_reg      <= '0;
            exe_uses_src2_reg <= 1'b0;
            mem_reg           <= '0;
            wb_reg            <= '0;
            stall_count_reg   <= '0;
        end else if (!bus.freeze) begin
            wb_reg            <= mem_reg;
            mem_reg           <= exe_wr_reg;
            exe_wr_reg        <= exe_wr_next;
            exe_src1_reg      <= exe_src1_next;
            exe_src2_reg      <= exe_src2_next;
            exe_uses_src2_reg <= exe_uses_src2_next;
            stall_count_reg   <= stall_count_next;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign bus.fwd_sel1     = fwd_sel[0];
    assign bus.fwd_sel2     = fwd_sel[1];
    assign bus.hazard_stall = hazard_stall;
    assign bus.stall_count  = stall_count_reg;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
//------------------------------------------------------------------------------
// tb_fwd_hazard_scoreboard
//
// Directed scenarios for fwd_hazard_scoreboard. Expected values are written
// out per scenario for both builds (FORWARDING_EN defined or not). A second
// instance with a 2-bit counter, fed the same stimulus, exercises counter
// saturation within a short run.
//------------------------------------------------------------------------------
module tb_fwd_hazard_scoreboard;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int exp_count   = 0;

    fwd_hazard_scoreboard_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();
    fwd_hazard_scoreboard_if #(.REG_ADDR_W(5), .CNT_W(2))  sat_bus ();

    fwd_hazard_scoreboard #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    fwd_hazard_scoreboard #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sat_bus.slave)
    );

    assign sat_bus.freeze       = bus.freeze;
    assign sat_bus.flush        = bus.flush;
    assign sat_bus.id_valid     = bus.id_valid;
    assign sat_bus.id_src1      = bus.id_src1;
    assign sat_bus.id_src2      = bus.id_src2;
    assign sat_bus.id_uses_src2 = bus.id_uses_src2;
    assign sat_bus.id_wb_en     = bus.id_wb_en;
    assign sat_bus.id_mem_read  = bus.id_mem_read;
    assign sat_bus.id_dest      = bus.id_dest;

    always #5 clk = ~clk;

    //--------------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    //--------------------------------------------------------------------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic v, input logic wb, input logic mr,
                          input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic u2);
        bus.id_valid     = v;
        bus.id_wb_en     = wb;
        bus.id_mem_read  = mr;
        bus.id_dest      = d;
        bus.id_src1      = s1;
        bus.id_src2      = s2;
        bus.id_uses_src2 = u2;
    endtask

    task automatic alu(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        id_set(1'b1, 1'b1, 1'b0, d, s1, s2, 1'b1);
    endtask

    task automatic load(input logic [4:0] d, input logic [4:0] base);
        id_set(1'b1, 1'b1, 1'b1, d, base, 5'd0, 1'b0);
    endtask

    task automatic nop;
        id_set(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic drain;
        nop;
        repeat (3) tick;
    endtask

    //--------------------------------------------------------------------------
    // Scenarios
    //--------------------------------------------------------------------------
    task automatic test_reset;
        drain;
        load(5'd8, 5'd1); #1;
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL rst_idle_stall got %0b want 0", bus.hazard_stall); end
        tick; alu(5'd9, 5'd8, 5'd8); #1;
        vectors++; if (bus.hazard_stall !== 1'b1) begin miscompares++; $display("FAIL rst_pre_stall got %0b want 1", bus.hazard_stall); end
        tick; #1;
        vectors++; if (bus.stall_count !== 16'd1) begin miscompares++; $display("FAIL rst_pre_count got %0d want 1", bus.stall_count); end
        vectors++; if (bus.hazard_stall !== !FWD) begin miscompares++; $display("FAIL rst_pre_stall2 got %0b want %0b", bus.hazard_stall, !FWD); end
        // asynchronous reset in the middle of a cycle, slots populated
        rst = 1'b0; #1;
        vectors++; if (bus.stall_count !== 16'd0) begin miscompares++; $display("FAIL rst_async_count got %0d want 0", bus.stall_count); end
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL rst_async_stall got %0b want 0", bus.hazard_stall); end
        vectors++; if (bus.fwd_sel1 !== 2'd0 || bus.fwd_sel2 !== 2'd0) begin miscompares++; $display("FAIL rst_async_sel got %0d/%0d want 0/0", bus.fwd_sel1, bus.fwd_sel2); end
        tick; #1;
        vectors++; if (bus.stall_count !== 16'd0) begin miscompares++; $display("FAIL rst_held_count got %0d want 0", bus.stall_count); end
        #2; rst = 1'b1;
        nop; tick;
        exp_count = 0;
        // add r3,r1,r2 ; sub r4,r3,r5
        alu(5'd3, 5'd1, 5'd2); #1;
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL post_rst_first got %0b want 0", bus.hazard_stall); end
        tick; alu(5'd4, 5'd3, 5'd5); #1;
`ifdef FORWARDING_EN
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL post_rst_dep_stall got %0b want 0", bus.hazard_stall); end
        tick; nop; #1;
        vectors++; if (bus.fwd_sel1 !== 2'd1) begin miscompares++; $display("FAIL post_rst_sel1 got %0d want 1", bus.fwd_sel1); end
        vectors++; if (bus.fwd_sel2 !== 2'd0) begin miscompares++; $display("FAIL post_rst_sel2 got %0d want 0", bus.fwd_sel2); end
`else
        vectors++; if (bus.hazard_stall !== 1'b1) begin miscompares++; $display("FAIL nofwd_stall_c1 got %0b want 1", bus.hazard_stall); end
        tick; #1;
        vectors++; if (bus.hazard_stall !== 1'b1) begin miscompares++; $display("FAIL nofwd_stall_c2 got %0b want 1", bus.hazard_stall); end
        tick; #1;
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL nofwd_stall_c3 got %0b want 0", bus.hazard_stall); end
        exp_count = 2;
        tick; nop; #1;
        vectors++; if (bus.fwd_sel1 !== 2'd0 || bus.fwd_sel2 !== 2'd0) begin miscompares++; $display("FAIL nofwd_sel got %0d/%0d want 0/0", bus.fwd_sel1, bus.fwd_sel2); end
`endif
        vectors++; if (bus.stall_count !== 16'(exp_count)) begin miscompares++; $display("FAIL post_rst_count got %0d want %0d", bus.stall_count, exp_count); end
    endtask

    task automatic test_wb_forward;
        // add r3 ; nop ; or r6,r3,r3
        drain;
        alu(5'd3, 5'd1, 5'd2); tick; nop; tick; alu(5'd6, 5'd3, 5'd3); #1;
`ifdef FORWARDING_EN
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL wb_stall got %0b want 0", bus.hazard_stall); end
        tick; nop; #1;
        vectors++; if (bus.fwd_sel1 !== 2'd2) begin miscompares++; $display("FAIL wb_sel1 got %0d want 2", bus.fwd_sel1); end
        vectors++; if (bus.fwd_sel2 !== 2'd2) begin miscompares++; $display("FAIL wb_sel2 got %0d want 2", bus.fwd_sel2); end
`else
        vectors++; if (bus.hazard_stall !== 1'b1) begin miscompares++; $display("FAIL wb_stall got %0b want 1", bus.hazard_stall); end
        tick; #1;
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL wb_stall_end got %0b want 0", bus.hazard_stall); end
        exp_count += 1;
        tick; nop; #1;
        vectors++; if (bus.fwd_sel1 !== 2'd0 || bus.fwd_sel2 !== 2'd0) begin miscompares++; $display("FAIL wb_sel got %0d/%0d want 0/0", bus.fwd_sel1, bus.fwd_sel2); end
`endif
        // add r3 ; add r3 ; and r7,r3,r0
        drain;
        alu(5'd3, 5'd1, 5'd2); tick; alu(5'd3, 5'd10, 5'd11); #1;
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL prio_indep_stall got %0b want 0", bus.hazard_stall); end
        tick; alu(5'd7, 5'd3, 5'd0); #1;
`ifdef FORWARDING_EN
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL prio_stall got %0b want 0", bus.hazard_stall); end
        tick; nop; #1;
        vectors++; if (bus.fwd_sel1 !== 2'd1) begin miscompares++; $display("FAIL prio_sel1 got %0d want 1", bus.fwd_sel1); end
        vectors++; if (bus.fwd_sel2 !== 2'd0) begin miscompares++; $display("FAIL prio_sel2 got %0d want 0", bus.fwd_sel2); end
`else
        vectors++; if (bus.hazard_stall !== 1'b1) begin miscompares++; $display("FAIL prio_stall_c1 got %0b want 1", bus.hazard_stall); end
        tick; #1;
        vectors++; if (bus.hazard_stall !== 1'b1) begin miscompares++; $display("FAIL prio_stall_c2 got %0b want 1", bus.hazard_stall); end
        tick; #1;
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL prio_stall_c3 got %0b want 0", bus.hazard_stall); end
        exp_count += 2;
        tick; nop; #1;
        vectors++; if (bus.fwd_sel1 !== 2'd0) begin miscompares++; $display("FAIL prio_sel1 got %0d want 0", bus.fwd_sel1); end
`endif
        vectors++; if (bus.stall_count !== 16'(exp_count)) begin miscompares++; $display("FAIL wb_count got %0d want %0d", bus.stall_count, exp_count); end
    endtask

    task automatic test_load_use;
        // lw r8 ; add r9,r8,r1
        drain;
        load(5'd8, 5'd1); #1;
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL lu_load_stall got %0b want 0", bus.hazard_stall); end
        tick; alu(5'd9, 5'd8, 5'd1); #1;
        vectors++; if (bus.hazard_stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall got %0b want 1", bus.hazard_stall); end
        tick; exp_count += 1; #1;
`ifdef FORWARDING_EN
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL lu_stall_once got %0b want 0", bus.hazard_stall); end
        vectors++; if (bus.fwd_sel1 !== 2'd0) begin miscompares++; $display("FAIL lu_bubble_sel1 got %0d want 0", bus.fwd_sel1); end
        vectors++; if (bus.stall_count !== 16'(exp_count)) begin miscompares++; $display("FAIL lu_count got %0d want %0d", bus.stall_count, exp_count); end
        tick; nop; #1;
        vectors++; if (bus.fwd_sel1 !== 2'd2) begin miscompares++; $display("FAIL lu_sel1 got %0d want 2", bus.fwd_sel1); end
        vectors++; if (bus.fwd_sel2 !== 2'd0) begin miscompares++; $display("FAIL lu_sel2 got %0d want 0", bus.fwd_sel2); end
`else
        vectors++; if (bus.hazard_stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall_c2 got %0b want 1", bus.hazard_stall); end
        tick; exp_count += 1; #1;
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL lu_stall_c3 got %0b want 0", bus.hazard_stall); end
        vectors++; if (bus.stall_count !== 16'(exp_count)) begin miscompares++; $display("FAIL lu_count got %0d want %0d", bus.stall_count, exp_count); end
        tick; nop; #1;
        vectors++; if (bus.fwd_sel1 !== 2'd0) begin miscompares++; $display("FAIL lu_sel1 got %0d want 0", bus.fwd_sel1); end
`endif
    endtask

    task automatic test_r0_flush;
        // lw r0 ; add r1,r0,r0
        drain;
        load(5'd0, 5'd1); tick; alu(5'd1, 5'd0, 5'd0); #1;
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL r0_stall got %0b want 0", bus.hazard_stall); end
        tick; nop; #1;
        vectors++; if (bus.fwd_sel1 !== 2'd0 || bus.fwd_sel2 !== 2'd0) begin miscompares++; $display("FAIL r0_sel got %0d/%0d want 0/0", bus.fwd_sel1, bus.fwd_sel2); end
        // lw r8 ; (flushed) lw r12,0(r8) ; add r13,r12,r12
        drain;
        load(5'd8, 5'd1); tick;
        bus.flush = 1'b1; load(5'd12, 5'd8); #1;
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall got %0b want 0", bus.hazard_stall); end
        tick; bus.flush = 1'b0; alu(5'd13, 5'd12, 5'd12); #1;
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL flush_bubble_stall got %0b want 0", bus.hazard_stall); end
        tick; nop; #1;
        vectors++; if (bus.fwd_sel1 !== 2'd0) begin miscompares++; $display("FAIL flush_bubble_sel1 got %0d want 0", bus.fwd_sel1); end
        vectors++; if (bus.stall_count !== 16'(exp_count)) begin miscompares++; $display("FAIL flush_count got %0d want %0d", bus.stall_count, exp_count); end
    endtask

    task automatic test_freeze;
        drain;
        load(5'd8, 5'd1); tick; alu(5'd9, 5'd8, 5'd1); #1;
        vectors++; if (bus.hazard_stall !== 1'b1) begin miscompares++; $display("FAIL frz_stall got %0b want 1", bus.hazard_stall); end
        bus.freeze = 1'b1;
        tick; tick; #1;
        vectors++; if (bus.hazard_stall !== 1'b1) begin miscompares++; $display("FAIL frz_hold_stall got %0b want 1", bus.hazard_stall); end
        vectors++; if (bus.stall_count !== 16'(exp_count)) begin miscompares++; $display("FAIL frz_count got %0d want %0d", bus.stall_count, exp_count); end
        bus.freeze = 1'b0;
        tick; exp_count += 1; #1;
        vectors++; if (bus.stall_count !== 16'(exp_count)) begin miscompares++; $display("FAIL frz_release_count got %0d want %0d", bus.stall_count, exp_count); end
`ifdef FORWARDING_EN
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL frz_after_stall got %0b want 0", bus.hazard_stall); end
        tick; nop; #1;
        vectors++; if (bus.fwd_sel1 !== 2'd2) begin miscompares++; $display("FAIL frz_sel1 got %0d want 2", bus.fwd_sel1); end
`else
        vectors++; if (bus.hazard_stall !== 1'b1) begin miscompares++; $display("FAIL frz_after_stall got %0b want 1", bus.hazard_stall); end
        tick; exp_count += 1; #1;
        vectors++; if (bus.hazard_stall !== 1'b0) begin miscompares++; $display("FAIL frz_end_stall got %0b want 0", bus.hazard_stall); end
        tick; nop; #1;
        vectors++; if (bus.fwd_sel1 !== 2'd0) begin miscompares++; $display("FAIL frz_sel1 got %0d want 0", bus.fwd_sel1); end
`endif
    endtask

    task automatic test_saturation;
        int sat_exp;
        sat_exp = (exp_count > 3) ? 3 : exp_count;
        vectors++; if (sat_bus.stall_count !== 2'(sat_exp)) begin miscompares++; $display("FAIL sat_start got %0d want %0d", sat_bus.stall_count, sat_exp); end
        for (int k = 0; k < 3; k++) begin
            drain;
            load(5'd8, 5'd1); tick; alu(5'd9, 5'd8, 5'd1); #1;
            vectors++; if (bus.hazard_stall !== 1'b1) begin miscompares++; $display("FAIL sat_stall[%0d] got %0b want 1", k, bus.hazard_stall); end
            tick; exp_count += 1;
`ifndef FORWARDING_EN
            tick; exp_count += 1;
`endif
            #1;
            sat_exp = (exp_count > 3) ? 3 : exp_count;
            vectors++; if (bus.stall_count !== 16'(exp_count)) begin miscompares++; $display("FAIL sat_main_count[%0d] got %0d want %0d", k, bus.stall_count, exp_count); end
            vectors++; if (sat_bus.stall_count !== 2'(sat_exp)) begin miscompares++; $display("FAIL sat_count[%0d] got %0d want %0d", k, sat_bus.stall_count, sat_exp); end
        end
    endtask

    //--------------------------------------------------------------------------
    // Sequence
    //--------------------------------------------------------------------------
    initial begin
        bus.freeze = 1'b0;
        bus.flush  = 1'b0;
        nop;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        $display("reset released, FORWARDING_EN=%0b", FWD);
        test_reset;
        $display("test_reset done, %0d vectors so far", vectors);
        test_wb_forward;
        $display("test_wb_forward done, %0d vectors so far", vectors);
        test_load_use;
        $display("test_load_use done, %0d vectors so far", vectors);
        test_r0_flush;
        $display("test_r0_flush done, %0d vectors so far", vectors);
        test_freeze;
        $display("test_freeze done, %0d vectors so far", vectors);
        test_saturation;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Tracks in-flight register writers in the EXE, MEM and WB stages of the 5-stage pipeline.
- Generates the 2-bit select inputs for the EXE-stage 3-input operand muxes: 0 = ID/EX register value, 1 = MEM-stage ALU result, 2 = WB-stage write data.
- Generates the load-use stall that holds PC and IF/ID.
- Sits between ID decode and the EXE operand muxes.

Parameters:
REG_ADDR_W, 5, register index width
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
freeze  in  1  global pipeline hold; all slots keep state
flush  in  1  branch taken; instruction in ID is discarded
id_valid  in  1  ID holds a real instruction
id_src1  in  REG_ADDR_W  ID source register 1
id_src2  in  REG_ADDR_W  ID source register 2
id_uses_src2  in  1  src2 is read (R-type, store, branch)
id_wb_en  in  1  ID instruction writes a register
id_mem_read  in  1  ID instruction is a load
id_dest  in  REG_ADDR_W  ID destination register
fwd_sel1  out  2  select for operand-1 mux in EXE
fwd_sel2  out  2  select for operand-2 mux in EXE
hazard_stall  out  1  hold PC and IF/ID; insert bubble in EXE
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Three slots: EXE, MEM, WB.
  - Each slot holds valid, wb_en, mem_read, dest.
  - The EXE slot also holds src1, src2, uses_src2.
- Reset (rst=0, async): all slot fields 0, stall_count=0. Outputs are then fwd_sel1=fwd_sel2=0 and hazard_stall=0.
- Advance at rising clk when freeze=0:
  - WB <= MEM, MEM <= EXE.
  - EXE <= ID fields if id_valid & ~flush & ~hazard_stall; otherwise EXE <= bubble (all fields 0).
- freeze=1: all slots and stall_count hold. freeze has priority over flush and stall. Upstream keeps flush asserted until freeze drops.
- A slot "writes r" when valid & wb_en & dest==r & r!=0. Register 0 is never forwarded and never causes a stall.
- fwd_sel1 (combinational from slot state only; no input-to-output path):
  - 1 if MEM writes EXE.src1.
  - else 2 if WB writes EXE.src1.
  - else 0.
  - MEM has priority over WB.
- fwd_sel2: same rule, using EXE.src2. Forced 0 if EXE.uses_src2=0.
- hazard_stall = id_valid & ~flush & EXE.mem_read & (EXE writes id_src1 | (id_uses_src2 & EXE writes id_src2)).
  - Combinational from ID inputs plus state.
  - Lasts exactly 1 cycle per load-use pair. The load moves to MEM and the value is then forwarded from WB.
- stall_count increments on each non-frozen clock with hazard_stall=1. It saturates at all-ones and never wraps.
- The register file is write-first, so a WB writer needs no stall in either mode.
- Reset mid-operation clears all slots immediately. The first post-reset instruction sees no hazards.

Optional Feature:
Macro FORWARDING_EN.
- Defined: behaviour as above.
- Undefined:
  - fwd_sel1 and fwd_sel2 are tied to 0.
  - hazard_stall = id_valid & ~flush & (EXE or MEM writes id_src1 | (id_uses_src2 & (EXE or MEM writes id_src2))), regardless of mem_read.
  - A dependent instruction directly behind its writer stalls 2 cycles; one a single instruction behind stalls 1 cycle.

Test Plan:
- Reset: drive rst=0 mid-stream with slots populated -> all outputs 0 asynchronously. Then `add r3,r1,r2` followed by `sub r4,r3,r5` -> fwd_sel1=1 in the sub's EXE cycle, fwd_sel2=0, hazard_stall=0 throughout.
- WB forward with MEM priority:
  - `add r3`, `nop`, `or r6,r3,r3` -> fwd_sel1=2, fwd_sel2=2.
  - `add r3`, `add r3`, `and r7,r3,r0` -> fwd_sel1=1 (MEM wins), fwd_sel2=0.
- Load-use: `lw r8`, `add r9,r8,r1` -> hazard_stall=1 for exactly 1 cycle, EXE gets a bubble, then fwd_sel1=2. stall_count 0 -> 1.
- r0 and flush:
  - `lw r0` then `add r1,r0,r0` -> no stall, selects 0.
  - `lw r8` then a dependent instruction in ID with flush=1 -> hazard_stall=0 and the EXE slot becomes a bubble.
- Freeze and saturation:
  - freeze=1 during a load-use stall -> slots hold, stall_count unchanged.
  - Preload stall_count to 16'hFFFF and stall again -> stays 16'hFFFF.
- FORWARDING_EN undefined: `add r3`, `sub r4,r3,r5` -> hazard_stall=1 for 2 cycles, fwd_sel1=0 always, stall_count +2.
